// File: rtl/fir_filter_mc_if.sv
// Handshake and coefficient-bus bundle for fir_filter_mc.
// The master side drives samples, coefficient writes and out_ready; the slave side is the filter.
interface fir_filter_mc_if #(
  parameter int TAPS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int CHANNELS   = 2
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [CH_W-1:0]       in_chan;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  coef_we;
  logic [TAP_W-1:0]      coef_addr;
  logic [COEF_WIDTH-1:0] coef_data;
  logic                  coef_drop;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH_W-1:0]       out_chan;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_chan, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, coef_drop, out_valid, out_chan, out_data
  );

  modport slave (
    input  in_valid, in_chan, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, coef_drop, out_valid, out_chan, out_data
  );
endinterface

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one signed MAC walks all taps per sample,
// each channel owns its delay line, and results are rounded and saturated.
module fir_filter_mc #(
  parameter int TAPS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int OUT_SHIFT  = 15
) (
  input logic           clk,
  input logic           rst_n,
  fir_filter_mc_if.slave bus
);
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + TAP_W;
  localparam int RND_SH     = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [CH_W:0]      CH_LIM  = (CH_W+1)'(CHANNELS);
  localparam logic [TAP_W:0]     TAP_LIM = (TAP_W+1)'(TAPS);
  localparam logic [TAP_W-1:0]   K_LAST  = TAP_W'(TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND =
    (OUT_SHIFT > 0) ? (ACC_WIDTH'(1) << RND_SH) : '0;
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q [CHANNELS][TAPS];
  logic signed [DATA_WIDTH-1:0] x_d [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] c_q [TAPS];
  logic signed [COEF_WIDTH-1:0] c_d [TAPS];
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [TAP_W-1:0]             k_q, k_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]              out_chan_q, out_chan_d;
  logic                         coef_drop_q, coef_drop_d;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  rounded;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic                         chan_ok;

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.coef_drop = coef_drop_q;

  assign chan_ok = ({1'b0, bus.in_chan} < CH_LIM);
  assign prod    = x_q[ch_q][k_q] * c_q[k_q];
  assign rounded = acc_q + RND;
  assign shifted = rounded >>> OUT_SHIFT;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    k_d         = k_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    coef_drop_d = 1'b0;

    // Coefficients only change while idle, so an in-flight sample never sees a mixed set.
    if (bus.coef_we) begin
      if (state_q == IDLE && ({1'b0, bus.coef_addr} < TAP_LIM)) begin
        c_d[bus.coef_addr] = bus.coef_data;
      end else begin
        coef_drop_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid && chan_ok) begin
          for (int i = TAPS - 1; i > 0; i--) begin
            x_d[bus.in_chan][i] = x_q[bus.in_chan][i-1];
          end
          x_d[bus.in_chan][0] = bus.in_data;
          ch_d    = bus.in_chan;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{TAP_W{prod[PROD_WIDTH-1]}}, prod};
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (shifted > MAXV) begin
          out_data_d = MAXV[DATA_WIDTH-1:0];
        end else if (shifted < MINV) begin
          out_data_d = MINV[DATA_WIDTH-1:0];
        end else begin
          out_data_d = shifted[DATA_WIDTH-1:0];
        end
        out_chan_d  = ch_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      c_q         <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      coef_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      coef_drop_q <= coef_drop_d;
    end
  end
endmodule

// File: tb/tb_fir_filter_mc.sv
// Bench for fir_filter_mc: directed scenarios plus random traffic, all checked
// against an arithmetic model of the filter equation.
module tb_fir_filter_mc;
  localparam int TAPS = 4;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int CH   = 2;
  localparam int SH   = 15;
  localparam int LAT  = TAPS + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int   mx [CH][TAPS];
  int   mc [TAPS];

  fir_filter_mc_if #(.TAPS(TAPS), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .CHANNELS(CH)) bus ();
  fir_filter_mc_if #(.TAPS(3), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .CHANNELS(CH)) bus3 ();

  fir_filter_mc #(.TAPS(TAPS), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .CHANNELS(CH), .OUT_SHIFT(SH))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  fir_filter_mc #(.TAPS(3), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .CHANNELS(CH), .OUT_SHIFT(SH))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < TAPS; k++) mx[c][k] = 0;
    for (int k = 0; k < TAPS; k++) mc[k] = 0;
  endfunction

  // y = sat(round(sum_k x[n-k]*c[k] / 2^SH))
  function automatic int model_eval(input int ch, input int d);
    longint acc;
    longint maxv;
    longint minv;
    acc  = 0;
    maxv = (longint'(1) << (DW - 1)) - 1;
    minv = -(longint'(1) << (DW - 1));
    for (int k = TAPS - 1; k > 0; k--) mx[ch][k] = mx[ch][k-1];
    mx[ch][0] = sx16(d);
    for (int k = 0; k < TAPS; k++) acc += longint'(mx[ch][k]) * longint'(mc[k]);
    if (SH > 0) acc += longint'(1) << (SH - 1);
    acc = acc >>> SH;
    if (acc > maxv) acc = maxv;
    if (acc < minv) acc = minv;
    return int'(acc);
  endfunction

  task automatic write_coef(input int addr, input int val);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'(addr);
    bus.coef_data = 16'(val);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    mc[addr] = sx16(val);
  endtask

  task automatic load_impulse_coefs();
    write_coef(0, 'h4000);
    write_coef(1, 'h2000);
    write_coef(2, 'h1000);
    write_coef(3, 'h0800);
  endtask

  // Sends one sample (optionally with a same-edge coefficient write) and collects the result.
  task automatic run_sample(input int ch, input int data, input bit we, input int waddr,
                            input int wdata, output int got_data, output int got_chan,
                            output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid  = 1'b1;
    bus.in_chan   = 1'(ch);
    bus.in_data   = 16'(data);
    bus.coef_we   = we;
    bus.coef_addr = 2'(waddr);
    bus.coef_data = 16'(wdata);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    got_data = sx16(int'(bus.out_data));
    got_chan = int'(bus.out_chan);
    if (lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_chan    = '0;
    bus.in_data    = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_data  = '0;
    bus.out_ready  = 1'b1;
    bus3.in_valid  = 1'b0;
    bus3.in_chan   = '0;
    bus3.in_data   = '0;
    bus3.coef_we   = 1'b0;
    bus3.coef_addr = '0;
    bus3.coef_data = '0;
    bus3.out_ready = 1'b1;
    model_clear();
    #2;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_chan !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%h chan=%b expected 0/0000/0",
               bus.out_valid, bus.out_data, bus.out_chan);
    end
    checks++;
    if (bus.coef_drop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_coef_drop: got %b expected 0", bus.coef_drop);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_impulse();
    int seq [5] = '{'h4000, 0, 0, 0, 0};
    int d, c, l, exp;
    load_impulse_coefs();
    for (int i = 0; i < 5; i++) begin
      exp = model_eval(0, seq[i]);
      run_sample(0, seq[i], 1'b0, 0, 0, d, c, l);
      checks++;
      if (d !== exp || c !== 0 || l !== LAT) begin
        errors++;
        $display("[TB] FAIL impulse[%0d]: got data=%h chan=%0d lat=%0d expected %h/0/%0d",
                 i, 16'(d), c, l, 16'(exp), LAT);
      end
    end
  endtask

  task automatic test_saturation();
    int d, c, l, exp;
    for (int k = 0; k < TAPS; k++) write_coef(k, 'h7FFF);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        exp = model_eval(0, pass == 0 ? 'h7FFF : 'h8000);
        run_sample(0, pass == 0 ? 'h7FFF : 'h8000, 1'b0, 0, 0, d, c, l);
        checks++;
        if (d !== exp || l !== LAT) begin
          errors++;
          $display("[TB] FAIL saturation[%0d][%0d]: got data=%h lat=%0d expected %h/%0d",
                   pass, i, 16'(d), l, 16'(exp), LAT);
        end
      end
      checks++;
      if (16'(d) !== (pass == 0 ? 16'h7FFF : 16'h8000)) begin
        errors++;
        $display("[TB] FAIL saturation_clamp[%0d]: got %h expected %h",
                 pass, 16'(d), pass == 0 ? 16'h7FFF : 16'h8000);
      end
    end
  endtask

  task automatic test_isolation();
    int d, c, l, exp;
    int ch1_ref [4] = '{'h0080, 'h00C0, 'h00E0, 'h00F0};
    load_impulse_coefs();
    for (int i = 0; i < TAPS; i++) begin
      exp = model_eval(0, 0);
      run_sample(0, 0, 1'b0, 0, 0, d, c, l);
    end
    for (int i = 0; i < 4; i++) begin
      exp = model_eval(0, i == 0 ? 'h4000 : 0);
      run_sample(0, i == 0 ? 'h4000 : 0, 1'b0, 0, 0, d, c, l);
      checks++;
      if (d !== exp || c !== 0 || l !== LAT) begin
        errors++;
        $display("[TB] FAIL isolation_ch0[%0d]: got data=%h chan=%0d lat=%0d expected %h/0/%0d",
                 i, 16'(d), c, l, 16'(exp), LAT);
      end
      exp = model_eval(1, 'h0100);
      run_sample(1, 'h0100, 1'b0, 0, 0, d, c, l);
      checks++;
      if (d !== exp || d !== ch1_ref[i] || c !== 1 || l !== LAT) begin
        errors++;
        $display("[TB] FAIL isolation_ch1[%0d]: got data=%h chan=%0d lat=%0d expected %h/1/%0d",
                 i, 16'(d), c, l, 16'(ch1_ref[i]), LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int exp, l;
    logic [15:0] d0;
    logic        c0;
    bit          bad;
    exp = model_eval(1, 'h1234);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_chan   = 1'b1;
    bus.in_data   = 16'h1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        l = i;
        break;
      end
    end
    d0 = bus.out_data;
    c0 = bus.out_chan;
    checks++;
    if (sx16(int'(d0)) !== exp || c0 !== 1'b1 || l !== LAT) begin
      errors++;
      $display("[TB] FAIL backpressure_result: got data=%h chan=%b lat=%0d expected %h/1/%0d",
               d0, c0, l, 16'(exp), LAT);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.out_chan !== c0 ||
          bus.in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: got valid=%b data=%h ready=%b expected 1/%h/0",
               bus.out_valid, bus.out_data, bus.in_ready, d0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got valid=%b ready=%b expected 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_coef_drop();
    int exp, l, d, c;
    exp = model_eval(0, 'h2000);
    bus.in_valid = 1'b1;
    bus.in_chan  = 1'b0;
    bus.in_data  = 16'h2000;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd0;
    bus.coef_data = 16'h1234;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    checks++;
    if (bus.coef_drop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_in_mac_pulse: got %b expected 1", bus.coef_drop);
    end
    l = -1;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 2 && bus.coef_drop !== 1'b0) begin
        errors++;
        $display("[TB] FAIL drop_in_mac_width: got %b expected 0", bus.coef_drop);
      end
      if (i == 2) checks++;
      if (bus.out_valid) begin
        l = i;
        break;
      end
    end
    checks++;
    if (sx16(int'(bus.out_data)) !== exp || l !== LAT) begin
      errors++;
      $display("[TB] FAIL drop_in_mac_result: got data=%h lat=%0d expected %h/%0d",
               bus.out_data, l, 16'(exp), LAT);
    end
    @(posedge clk); #1;
    mc[0] = sx16('h0C00);
    exp = model_eval(0, 'h4000);
    run_sample(0, 'h4000, 1'b1, 0, 'h0C00, d, c, l);
    checks++;
    if (d !== exp || l !== LAT) begin
      errors++;
      $display("[TB] FAIL coef_with_sample: got data=%h lat=%0d expected %h/%0d",
               16'(d), l, 16'(exp), LAT);
    end
    bus3.coef_we   = 1'b1;
    bus3.coef_addr = 2'd3;
    bus3.coef_data = 16'h5555;
    @(posedge clk); #1;
    bus3.coef_addr = 2'd2;
    checks++;
    if (bus3.coef_drop !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_addr_range: got %b expected 1", bus3.coef_drop);
    end
    @(posedge clk); #1;
    bus3.coef_we = 1'b0;
    checks++;
    if (bus3.coef_drop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_addr_valid: got %b expected 0", bus3.coef_drop);
    end
  endtask

  task automatic test_reset_mid_mac();
    int d, c, l, exp;
    bit seen;
    bus.in_valid = 1'b1;
    bus.in_chan  = 1'b0;
    bus.in_data  = 16'h4000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_mac_reset: got valid=%b ready=%b expected 0/0",
               bus.out_valid, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < TAPS + 4; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL mid_mac_no_result: got out_valid=1 expected none");
    end
    exp = model_eval(0, 'h4000);
    run_sample(0, 'h4000, 1'b0, 0, 0, d, c, l);
    checks++;
    if (d !== exp || d !== 0 || l !== LAT) begin
      errors++;
      $display("[TB] FAIL mid_mac_cleared: got data=%h lat=%0d expected 0000/%0d",
               16'(d), l, LAT);
    end
    load_impulse_coefs();
    for (int i = 0; i < 5; i++) begin
      exp = model_eval(0, i == 0 ? 'h4000 : 0);
      run_sample(0, i == 0 ? 'h4000 : 0, 1'b0, 0, 0, d, c, l);
      checks++;
      if (d !== exp || c !== 0 || l !== LAT) begin
        errors++;
        $display("[TB] FAIL mid_mac_reload[%0d]: got data=%h lat=%0d expected %h/%0d",
                 i, 16'(d), l, 16'(exp), LAT);
      end
    end
  endtask

  task automatic test_random();
    int d, c, l, exp, ch, val, addr, wval;
    bit we;
    for (int i = 0; i < 24; i++) begin
      ch   = int'($urandom_range(0, CH - 1));
      val  = int'($urandom_range(0, 65535));
      we   = ($urandom_range(0, 3) == 0);
      addr = int'($urandom_range(0, TAPS - 1));
      wval = int'($urandom_range(0, 65535));
      if (we) mc[addr] = sx16(wval);
      exp = model_eval(ch, val);
      run_sample(ch, val, we, addr, wval, d, c, l);
      checks++;
      if (d !== exp || c !== ch || l !== LAT) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got data=%h chan=%0d lat=%0d expected %h/%0d/%0d",
                 i, 16'(d), c, l, 16'(exp), ch, LAT);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_impulse();
    test_saturation();
    test_isolation();
    test_backpressure();
    test_coef_drop();
    test_reset_mid_mac();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
